// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        REDIRECT,
        HALTED
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Instruction fetches are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage PC sequencer: holds the fetch address until imem responds, and handles
// stalls, branch redirects (including ones that arrive mid-fetch) and halt.
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_ready,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             halt,
    output logic [31:0]      pc_out,
    output logic             imem_req,
    output logic             if_buf_en,
    output logic             if_flush_buf,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             halted
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  target;
    logic         active;

    assign active   = (state == FETCH) || (state == REDIRECT);
    assign imem_req = active;
    assign halted   = (state == HALTED);
    assign pc_out   = pc;

    always_comb begin
        if_buf_en    = 1'b0;
        if_flush_buf = 1'b0;
        unique case (state)
            FETCH: begin
                if (imem_ready && branch_taken) begin
                    if_buf_en    = 1'b1;
                    if_flush_buf = 1'b1;
                end else if (imem_ready && !hazard_stall) begin
                    if_buf_en = 1'b1;
                end
            end
            REDIRECT: begin
                if (imem_ready) begin
                    if_buf_en    = 1'b1;
                    if_flush_buf = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BOOT;
            pc     <= word_align(RESET_PC);
            target <= '0;
        end else begin
            unique case (state)
                BOOT: state <= FETCH;
                FETCH: begin
                    if (halt) begin
                        state <= HALTED;
                    end else if (imem_ready) begin
                        if (branch_taken) begin
                            pc <= word_align(branch_target);
                        end else if (!hazard_stall) begin
                            pc <= pc + PC_STEP;
                        end
                    end else if (branch_taken) begin
                        // Address must stay put until imem answers; park the target.
                        target <= word_align(branch_target);
                        state  <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (halt) begin
                        state  <= HALTED;
                        target <= '0;
                    end else if (imem_ready) begin
                        pc    <= branch_taken ? word_align(branch_target) : target;
                        state <= FETCH;
                    end else if (branch_taken) begin
                        target <= word_align(branch_target);
                    end
                end
                HALTED: ;
                default: state <= BOOT;
            endcase
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (active && !if_buf_en),
        .count(stall_cnt)
    );

endmodule
